// File: rtl/mips_div_pkg.sv
// Shared definitions for the multi-cycle MIPS divider: state encodings,
// default operand width and the matching iteration-counter width.
package mips_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_sign_adj.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to restore the sign of the quotient/remainder after the magnitude divide.
module div_sign_adj #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);

  // Negate when requested; the most negative value maps onto itself, which
  // is exactly the unsigned magnitude the divide core needs.
  always_comb begin
    o_val = i_neg ? ((~i_val) + WIDTH'(1)) : i_val;
  end

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle on
// magnitudes, followed by one sign-fix cycle. Quotient goes to LO and the
// remainder to HI. Optional macro SEQ_DIVIDER_DBZ_EN adds the div_by_zero flag.
module seq_divider
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
`ifdef SEQ_DIVIDER_DBZ_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       r_state;
  div_state_t       w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_q_neg;
  logic             r_r_neg;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_busy;

  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic             w_dvs_zero;

  // Operand magnitudes (only negated for signed requests).
  div_sign_adj #(.WIDTH(WIDTH)) u_abs_dvd (
    .i_neg (is_signed & dividend[WIDTH-1]),
    .i_val (dividend),
    .o_val (w_dvd_abs)
  );

  div_sign_adj #(.WIDTH(WIDTH)) u_abs_dvs (
    .i_neg (is_signed & divisor[WIDTH-1]),
    .i_val (divisor),
    .o_val (w_dvs_abs)
  );

  // Result sign restoration applied in the fix cycle.
  div_sign_adj #(.WIDTH(WIDTH)) u_fix_quo (
    .i_neg (r_q_neg),
    .i_val (r_quo),
    .o_val (w_quo_fix)
  );

  div_sign_adj #(.WIDTH(WIDTH)) u_fix_rem (
    .i_neg (r_r_neg),
    .i_val (r_rem),
    .o_val (w_rem_fix)
  );

  // The shifted partial remainder needs WIDTH+1 bits because it may exceed
  // WIDTH bits before the subtraction. When it is >= divisor the difference
  // is below the divisor, so its low WIDTH bits are exact.
  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_dvs});
  assign w_diff     = w_rem_sh[WIDTH-1:0] - r_dvs;
  assign w_dvs_zero = (r_dvs == '0);

  // Next-state logic: IDLE -> CALC for WIDTH cycles -> FIX -> IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DIV_IDLE: if (start) w_state_next = DIV_CALC;
      DIV_CALC: if (r_count == '0) w_state_next = DIV_FIX;
      DIV_FIX:  w_state_next = DIV_IDLE;
      default:  w_state_next = DIV_IDLE;
    endcase
  end

  // State register; reset aborts any operation in progress.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= DIV_IDLE;
    else      r_state <= w_state_next;
  end

  // Datapath: latch operands on accept, iterate, then publish signed results.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (start) begin
            r_rem   <= '0;
            r_quo   <= w_dvd_abs;
            r_dvs   <= w_dvs_abs;
            r_q_neg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_r_neg <= is_signed & dividend[WIDTH-1];
            r_count <= CNT_W'(WIDTH - 1);
            r_busy  <= 1'b1;
          end
        end
        DIV_CALC: begin
          r_rem   <= w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
          r_quo   <= {r_quo[WIDTH-2:0], w_ge};
          r_count <= r_count - CNT_W'(1);
        end
        DIV_FIX: begin
          // A zero divisor accepts every trial, leaving |dividend| in rem;
          // re-applying the dividend sign gives back the original operand.
          r_quotient  <= w_dvs_zero ? '1 : w_quo_fix;
          r_remainder <= w_rem_fix;
          r_busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_DIVIDER_DBZ_EN
  logic r_dbz;

  // Divide-by-zero flag: raised in the fix cycle, cleared by a new accepted start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dbz <= 1'b0;
    end else if (r_state == DIV_IDLE && start) begin
      r_dbz <= 1'b0;
    end else if (r_state == DIV_FIX) begin
      r_dbz <= w_dvs_zero;
    end
  end

  assign div_by_zero = r_dbz;
`endif

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign busy      = r_busy;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver pushes reference results into
// a queue, a monitor pops and compares whenever busy falls.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         dbz_flag;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy)
`ifdef SEQ_DIVIDER_DBZ_EN
    ,
    .div_by_zero(dbz_flag)
`endif
  );

`ifndef SEQ_DIVIDER_DBZ_EN
  assign dbz_flag = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  bit   skip_fall = 1'b0;
  bit   prev_busy = 1'b0;

  // Reference model: plain integer division with MIPS divide-by-zero rules.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t   e;
    longint sa;
    longint sb_v;
    e.a = a; e.b = b; e.s = s; e.dbz = 1'b0;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
`ifdef SEQ_DIVIDER_DBZ_EN
      e.dbz = 1'b1;
`endif
    end else if (s) begin
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      e.q  = W'(sa / sb_v);
      e.r  = W'(sa % sb_v);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compare results on every busy falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (prev_busy && !busy) begin
        if (skip_fall) begin
          skip_fall = 1'b0;
        end else if (sb.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          $display("txn s=%0d a=%h b=%h q=%h r=%h busy_cycles=%0d",
                   e.s, e.a, e.b, quotient, remainder, busy_cnt);
          check("quotient", quotient, e.q);
          check("remainder", remainder, e.r);
          check("div_by_zero", W'(dbz_flag), W'(e.dbz));
          check("busy_cycles", W'(busy_cnt), W'(W + 1));
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", W'(busy), '0);
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit push);
    wait_idle();
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom; divisor = $urandom; is_signed = $urandom_range(0, 1);
    if (push) sb.push_back(model(a, b, s));
  endtask

  initial begin
    exp_t h;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;

    repeat (3) @(negedge clk);
    check("reset_busy", W'(busy), '0);
    check("reset_quotient", quotient, '0);
    check("reset_remainder", remainder, '0);
    check("reset_dbz", W'(dbz_flag), '0);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases.
    start_op(32'd100, 32'd7, 1'b0, 1'b1);
    start_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    start_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    start_op(32'd5, 32'd0, 1'b0, 1'b1);
    start_op(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1);

    // Results must hold while idle.
    wait_idle();
    h = model(32'hFFFF_FFFB, 32'd0, 1'b1);
    repeat (4) @(negedge clk);
    check("hold_quotient", quotient, h.q);
    check("hold_remainder", remainder, h.r);

    // A second start during an op is ignored.
    start_op(32'd100, 32'd7, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    start = 1'b1; dividend = 32'd999; divisor = 32'd3; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;

    // Reset in the middle of an op aborts it.
    start_op(32'd1234, 32'd5, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    skip_fall = 1'b1;
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check("abort_busy", W'(busy), '0);
    check("abort_quotient", quotient, '0);
    check("abort_remainder", remainder, '0);
    check("abort_dbz", W'(dbz_flag), '0);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("abort_start_discarded", W'(busy), '0);
    start_op(32'd1234, 32'd5, 1'b0, 1'b1);

    // Randomized operations with occasional special divisors.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      s = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = '1;
        2:       b = W'($urandom_range(1, 15));
        3:       b = {16'hFFFF, 16'($urandom)};
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      start_op(a, b, s, 1'b1);
    end

    wait_idle();
    repeat (2) @(negedge clk);
    check("scoreboard_drain", W'(sb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
